// File: rtl/seq_ser_pkg.sv
// Shared types and constants for the seq_bit_serializer slice.
package seq_ser_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_e;

    localparam int unsigned SEQ_SER_DEFAULT_WIDTH = 8;
    localparam logic        SEQ_SER_IDLE_LEVEL    = 1'b0;

endpackage

// File: rtl/seq_ser_hold_reg.sv
// One-entry holding register with load/unload and a full flag.
// Used by seq_bit_serializer only when SEQ_SER_PRELOAD_EN is defined.
module seq_ser_hold_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             unload,
    output logic [WIDTH-1:0] data,
    output logic             full
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             full_q, full_d;

    // Next-state: a load always wins and marks the entry full.
    always_comb begin
        data_d = data_q;
        full_d = full_q;
        if (load) begin
            data_d = load_data;
            full_d = 1'b1;
        end else if (unload) begin
            full_d = 1'b0;
        end
    end

    // Entry storage, cleared on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else begin
            data_q <= data_d;
            full_q <= full_d;
        end
    end

    assign data = data_q;
    assign full = full_q;

endmodule

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words in over valid/ready,
// shifted out MSB-first one bit per enabled clock.
// Optional feature: define SEQ_SER_PRELOAD_EN to add a one-word hold
// register so back-to-back words stream with no idle bit between them.
module seq_bit_serializer
    import seq_ser_pkg::*;
#(
    parameter int unsigned WIDTH = SEQ_SER_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             last_bit,
    output logic             busy
);

    localparam int unsigned    CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    ser_state_e       state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             accept;

`ifdef SEQ_SER_PRELOAD_EN
    logic             hold_load;
    logic             hold_unload;
    logic             hold_full;
    logic [WIDTH-1:0] hold_data;

    seq_ser_hold_reg #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (hold_load),
        .load_data (in_data),
        .unload    (hold_unload),
        .data      (hold_data),
        .full      (hold_full)
    );

    assign in_ready = ena && !hold_full;
`else
    assign in_ready = ena && (state_q == IDLE);
`endif

    assign accept = in_valid && in_ready;

    // Next-state, shift and count; everything freezes while ena is low.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
`ifdef SEQ_SER_PRELOAD_EN
        hold_load   = 1'b0;
        hold_unload = 1'b0;
`endif
        if (ena) begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        shift_d = in_data;
                        cnt_d   = CNT_LAST;
                        state_d = SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt_q != '0) begin
                        shift_d = {shift_q[WIDTH-2:0], 1'b0};
                        cnt_d   = cnt_q - CW'(1);
`ifdef SEQ_SER_PRELOAD_EN
                        hold_load = accept;
`endif
                    end else begin
`ifdef SEQ_SER_PRELOAD_EN
                        // Held word takes priority; ready is low while hold is
                        // full, so an accept here can only be a direct load.
                        if (hold_full) begin
                            shift_d     = hold_data;
                            cnt_d       = CNT_LAST;
                            hold_unload = 1'b1;
                        end else if (accept) begin
                            shift_d = in_data;
                            cnt_d   = CNT_LAST;
                        end else begin
                            shift_d = '0;
                            state_d = IDLE;
                        end
`else
                        shift_d = '0;
                        state_d = IDLE;
`endif
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy      = (state_q == SHIFT);
    assign bit_valid = busy;
    assign bit_out   = busy ? shift_q[WIDTH-1] : SEQ_SER_IDLE_LEVEL;
    assign last_bit  = busy && (cnt_q == '0);

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Self-checking bench for seq_bit_serializer (WIDTH=8 main instance,
// WIDTH=2 secondary instance). Honours SEQ_SER_PRELOAD_EN if defined.
module tb_seq_bit_serializer;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ena = 1'b1;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready, bit_out, bit_valid, last_bit, busy;

    logic [1:0]   d2_in_data = '0;
    logic         d2_in_valid = 1'b0;
    logic         d2_in_ready, d2_bit_out, d2_bit_valid, d2_last_bit, d2_busy;

    int unsigned  vectors = 0;
    int unsigned  miscompares = 0;

    // Scoreboard of expected serial bits: {bit, last}
    logic [1:0]   exp_q[$];
    logic         obs_bit, obs_bv, obs_last, accepted;

    always #5 clk = ~clk;

    seq_bit_serializer #(.WIDTH(W)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .last_bit  (last_bit),
        .busy      (busy)
    );

    seq_bit_serializer #(.WIDTH(2)) u_dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .in_data   (d2_in_data),
        .in_valid  (d2_in_valid),
        .in_ready  (d2_in_ready),
        .bit_out   (d2_bit_out),
        .bit_valid (d2_bit_valid),
        .last_bit  (d2_last_bit),
        .busy      (d2_busy)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock of stimulus on the main DUT, checked against the queue model.
    task automatic step(input logic e, input logic v, input logic [W-1:0] d);
        logic m_ready, e_bv, e_b, e_l;
        @(negedge clk);
        ena = e;
        in_valid = v;
        in_data = d;
        #1;
`ifdef SEQ_SER_PRELOAD_EN
        m_ready = e && (exp_q.size() <= W);
`else
        m_ready = e && (exp_q.size() == 0);
`endif
        e_bv = (exp_q.size() != 0);
        e_b  = e_bv ? exp_q[0][1] : 1'b0;
        e_l  = e_bv ? exp_q[0][0] : 1'b0;
        check_val("bit_valid", {31'd0, bit_valid}, {31'd0, e_bv});
        check_val("bit_out",   {31'd0, bit_out},   {31'd0, e_b});
        check_val("last_bit",  {31'd0, last_bit},  {31'd0, e_l});
        check_val("busy",      {31'd0, busy},      {31'd0, e_bv});
        check_val("in_ready",  {31'd0, in_ready},  {31'd0, m_ready});
        obs_bit  = bit_out;
        obs_bv   = bit_valid;
        obs_last = last_bit;
        @(posedge clk);
        accepted = 1'b0;
        if (e) begin
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            if (v && m_ready) begin
                for (int i = W - 1; i >= 0; i--) exp_q.push_back({d[i], (i == 0)});
                accepted = 1'b1;
            end
        end
    endtask

    initial begin
        logic [16:0] s_bits, s_valid, e_bits, e_valid;
        logic [W-1:0] words[2];
        logic [1:0]  w2[3];
        logic [7:0]  c_bits, c_valid, c_last;
        int unsigned idx, cyc, sent, steps, k;
        logic        pending, rdy2;
        logic [W-1:0] word;

        // Reset values, no clock edge needed.
        #2;
        check_val("rst_bit_out",  {31'd0, bit_out},  32'd0);
        check_val("rst_valid",    {31'd0, bit_valid}, 32'd0);
        check_val("rst_last",     {31'd0, last_bit}, 32'd0);
        check_val("rst_busy",     {31'd0, busy},     32'd0);
        check_val("rst_ready_en", {31'd0, in_ready}, 32'd1);
        ena = 1'b0;
        #1;
        check_val("rst_ready_dis", {31'd0, in_ready}, 32'd0);
        ena = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        // Single word A5.
        step(1'b1, 1'b1, 8'hA5);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, '0);

        // A5 then 3C with valid held: collect 17 cycles after first accept.
        words[0] = 8'hA5;
        words[1] = 8'h3C;
        idx = 0;
        s_bits = '0;
        s_valid = '0;
        for (int c = 0; c < 18; c++) begin
            step(1'b1, idx < 2, (idx < 2) ? words[idx] : '0);
            if (c > 0) begin
                s_bits  = {s_bits[15:0], obs_bit};
                s_valid = {s_valid[15:0], obs_bv};
            end
            if (accepted) idx++;
        end
`ifdef SEQ_SER_PRELOAD_EN
        e_bits  = {8'hA5, 8'h3C, 1'b0};
        e_valid = {16'hFFFF, 1'b0};
`else
        e_bits  = {8'hA5, 1'b0, 8'h3C};
        e_valid = {8'hFF, 1'b0, 8'hFF};
`endif
        check_val("pair_stream", {15'd0, s_bits},  {15'd0, e_bits});
        check_val("pair_valid",  {15'd0, s_valid}, {15'd0, e_valid});
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, '0);

        // FF with a 3-cycle ena stall after bit 3.
        step(1'b1, 1'b1, 8'hFF);
        cyc = 0;
        steps = 0;
        do begin
            step((steps < 3 || steps > 5), 1'b0, '0);
            if (obs_bv) cyc++;
            steps++;
        end while (!obs_last && steps < 30);
        check_val("stall_span", cyc, 32'd11);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0);

        // 81 with asynchronous reset mid-word, after bit 2.
        step(1'b1, 1'b1, 8'h81);
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_bit_out", {31'd0, bit_out},   32'd0);
        check_val("arst_valid",   {31'd0, bit_valid}, 32'd0);
        check_val("arst_busy",    {31'd0, busy},      32'd0);
        check_val("arst_ready",   {31'd0, in_ready},  32'd1);
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, '0);

        // WIDTH=2 instance: 10, 01, 11 with valid held.
        w2[0] = 2'b10;
        w2[1] = 2'b01;
        w2[2] = 2'b11;
        k = 0;
        c_bits = '0;
        c_valid = '0;
        c_last = '0;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            if (c > 0) begin
                c_bits  = {c_bits[6:0], d2_bit_out};
                c_valid = {c_valid[6:0], d2_bit_valid};
                c_last  = {c_last[6:0], d2_last_bit};
            end
            d2_in_valid = (k < 3);
            d2_in_data  = (k < 3) ? w2[k] : 2'b00;
            #1;
            rdy2 = d2_in_valid && d2_in_ready;
            @(posedge clk);
            if (rdy2) k++;
        end
        d2_in_valid = 1'b0;
`ifdef SEQ_SER_PRELOAD_EN
        check_val("w2_bits",  {24'd0, c_bits},  32'b10011100);
        check_val("w2_valid", {24'd0, c_valid}, 32'b11111100);
        check_val("w2_last",  {24'd0, c_last},  32'b01010100);
`else
        check_val("w2_bits",  {24'd0, c_bits},  32'b10001011);
        check_val("w2_valid", {24'd0, c_valid}, 32'b11011011);
        check_val("w2_last",  {24'd0, c_last},  32'b01001001);
`endif
        check_val("w2_words", k, 32'd3);

        // Random valid/ena over 1000 words.
        sent = 0;
        steps = 0;
        pending = 1'b0;
        word = '0;
        while (sent < 1000 && steps < 40000) begin
            if (!pending && $urandom_range(0, 1) == 1) begin
                pending = 1'b1;
                word = W'($urandom);
            end
            step($urandom_range(0, 3) != 0, pending, word);
            if (accepted) begin
                pending = 1'b0;
                sent++;
            end
            steps++;
        end
        check_val("rand_words", sent, 32'd1000);
        for (int i = 0; i < 2 * W + 4; i++) step(1'b1, 1'b0, '0);
        check_val("drain_empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
